write_back: RTL and testbench

WRITE_BACK -- requirements
Module: write_back

---
 rtl/write_back_pkg.sv | 28 ++
 rtl/write_back.sv | 154 +++++++++++++++
 tb/tb_write_back.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/write_back_pkg.sv
// Shared core definitions for the write-back stage: write-data select,
// branch encodings and the stage FSM states.
package write_back_pkg;

   localparam int DATA_W   = 32;
   localparam int REG_AW   = 5;
   localparam int UART_W   = 8;

   typedef enum logic [1:0] {
      MTR_ALU  = 2'b00,
      MTR_MEM  = 2'b01,
      MTR_LINK = 2'b10,
      MTR_ALU2 = 2'b11
   } memtoreg_e;

   typedef enum logic [1:0] {
      BR_NONE  = 2'b00,
      BR_INDEX = 2'b01,
      BR_REG   = 2'b10,
      BR_COND  = 2'b11
   } branch_e;

   typedef enum logic {
      ST_RUN       = 1'b0,
      ST_UART_WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/write_back.sv
// Write-back stage: commits register writes and fetch redirects one cycle after
// issue, parking a UART-sourced instruction until its receive byte arrives.
module write_back
   import write_back_pkg::*;
#(
   parameter int INST_MEM_WIDTH = 2
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic                      distinct,
   input  logic                      RegWrite,
   input  logic [1:0]                MemtoReg,
   input  logic [1:0]                Branch,
   input  logic                      UARTtoReg,
   input  logic [31:0]               read_data,
   input  logic [31:0]               register_data,
   input  logic [31:0]               alu_result,
   input  logic [4:0]                rdist,
   input  logic [25:0]               inst_index,
   input  logic [INST_MEM_WIDTH-1:0] pc,
   input  logic [INST_MEM_WIDTH-1:0] pc1,
   input  logic [INST_MEM_WIDTH-1:0] pc2,
   input  logic                      uart_valid,
   input  logic [7:0]                uart_data,
   output logic                      uart_ready,
   output logic                      reg_we,
   output logic [4:0]                reg_waddr,
   output logic [31:0]               reg_wdata,
   output logic                      pc_load,
   output logic [INST_MEM_WIDTH-1:0] pc_target,
   output logic                      stall,
   output logic [31:0]               retired,
   input  logic                      i_dbg_preload,
   input  logic [31:0]               i_dbg_preload_value,
   output logic                      o_dbg_state
);

   state_e                    r_state, w_state_next;
   logic                      r_cap_we, r_cap_load;
   logic [REG_AW-1:0]         r_cap_waddr;
   logic [INST_MEM_WIDTH-1:0] r_cap_target;

   logic                      w_valid, w_taken, w_commit, w_capture;
   logic                      w_we, w_load, w_unused;
   logic [REG_AW-1:0]         w_waddr;
   logic [DATA_W-1:0]         w_mux_data, w_wdata;
   logic [INST_MEM_WIDTH-1:0] w_br_target, w_target;

   assign w_valid     = !distinct;
   assign o_dbg_state = r_state;
   // pc and the upper jump/register bits never reach a write-back output.
   assign w_unused    = ^{pc, inst_index, register_data};

   always_comb begin
      w_taken     = 1'b0;
      w_br_target = pc2;
      case (branch_e'(Branch))
         BR_INDEX: begin w_taken = 1'b1; w_br_target = inst_index[INST_MEM_WIDTH-1:0]; end
         BR_REG:   begin w_taken = 1'b1; w_br_target = register_data[INST_MEM_WIDTH-1:0]; end
         BR_COND:  begin w_taken = alu_result[0]; w_br_target = pc2; end
         default:  begin w_taken = 1'b0; w_br_target = pc2; end
      endcase
   end

   always_comb begin
      w_mux_data = alu_result;
      case (memtoreg_e'(MemtoReg))
         MTR_MEM:  w_mux_data = read_data;
         MTR_LINK: w_mux_data = DATA_W'(pc1);
         default:  w_mux_data = alu_result;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_commit     = 1'b0;
      w_capture    = 1'b0;
      w_we         = RegWrite && (rdist != '0);
      w_waddr      = rdist;
      w_wdata      = w_mux_data;
      w_load       = w_taken;
      w_target     = w_br_target;
      uart_ready   = 1'b0;
      stall        = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_valid) begin
               if (!UARTtoReg) begin
                  w_commit = 1'b1;
               end else begin
                  uart_ready = 1'b1;
                  if (uart_valid) begin
                     w_commit = 1'b1;
                     w_wdata  = {24'b0, uart_data};
                  end else begin
                     w_capture    = 1'b1;
                     stall        = 1'b1;
                     w_state_next = ST_UART_WAIT;
                  end
               end
            end
         end
         ST_UART_WAIT: begin
            uart_ready = 1'b1;
            stall      = 1'b1;
            if (uart_valid) begin
               w_commit     = 1'b1;
               w_we         = r_cap_we;
               w_waddr      = r_cap_waddr;
               w_wdata      = {24'b0, uart_data};
               w_load       = r_cap_load;
               w_target     = r_cap_target;
               w_state_next = ST_RUN;
            end
         end
         default: w_state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state      <= ST_RUN;
         reg_we       <= 1'b0;
         reg_waddr    <= '0;
         reg_wdata    <= '0;
         pc_load      <= 1'b0;
         pc_target    <= '0;
         retired      <= '0;
         r_cap_we     <= 1'b0;
         r_cap_waddr  <= '0;
         r_cap_load   <= 1'b0;
         r_cap_target <= '0;
      end else begin
         r_state <= w_state_next;
         reg_we  <= w_commit && w_we;
         pc_load <= w_commit && w_load;
         if (w_commit) begin
            reg_waddr <= w_waddr;
            reg_wdata <= w_wdata;
            if (w_load) pc_target <= w_target;
         end
         if (i_dbg_preload) retired <= i_dbg_preload_value;
         else if (w_commit) retired <= retired + 32'd1;
         // The redirect is resolved now so the parked slot needs no operands.
         if (w_capture) begin
            r_cap_we     <= RegWrite && (rdist != '0);
            r_cap_waddr  <= rdist;
            r_cap_load   <= w_taken;
            r_cap_target <= w_br_target;
         end
      end
   end

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: expected commits are queued by the driver and
// popped by a negedge monitor whenever the retired count advances by one.
module tb_write_back;
   import write_back_pkg::*;

   logic        clk, reset, distinct, RegWrite, UARTtoReg, uart_valid;
   logic [1:0]  MemtoReg, Branch, pc, pc1, pc2, pc_target;
   logic [31:0] read_data, register_data, alu_result, reg_wdata, retired;
   logic [4:0]  rdist, reg_waddr;
   logic [25:0] inst_index;
   logic [7:0]  uart_data;
   logic        uart_ready, reg_we, pc_load, stall, dbg_preload, dbg_state;
   logic [31:0] dbg_value;

   int          total = 0, bad = 0, hs_cnt = 0, hs0;
   logic [31:0] exp_retired = 0, last_ret = 0;
   logic [72:0] exp_q[$];

   write_back #(.INST_MEM_WIDTH(2)) dut (
      .CLK(clk), .reset(reset), .distinct(distinct), .RegWrite(RegWrite),
      .MemtoReg(MemtoReg), .Branch(Branch), .UARTtoReg(UARTtoReg),
      .read_data(read_data), .register_data(register_data), .alu_result(alu_result),
      .rdist(rdist), .inst_index(inst_index), .pc(pc), .pc1(pc1), .pc2(pc2),
      .uart_valid(uart_valid), .uart_data(uart_data), .uart_ready(uart_ready),
      .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .pc_load(pc_load), .pc_target(pc_target), .stall(stall), .retired(retired),
      .i_dbg_preload(dbg_preload), .i_dbg_preload_value(dbg_value), .o_dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      distinct = 1'b1; RegWrite = 1'b0; MemtoReg = 2'b00; Branch = 2'b00; UARTtoReg = 1'b0;
      read_data = '0; register_data = '0; alu_result = '0; rdist = '0; inst_index = '0;
      pc = '0; pc1 = '0; pc2 = '0;
   endtask

   task automatic issue(input logic rw, input logic [1:0] mtr, input logic [1:0] br,
                        input logic u2r, input logic [31:0] rd, input logic [31:0] rg,
                        input logic [31:0] alu, input logic [4:0] dst,
                        input logic [25:0] idx, input logic [1:0] p1, input logic [1:0] p2);
      distinct = 1'b0; RegWrite = rw; MemtoReg = mtr; Branch = br; UARTtoReg = u2r;
      read_data = rd; register_data = rg; alu_result = alu; rdist = dst;
      inst_index = idx; pc = 2'd1; pc1 = p1; pc2 = p2;
   endtask

   task automatic expect_commit(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ld, input logic [1:0] tg);
      exp_retired = exp_retired + 32'd1;
      exp_q.push_back({we, wa, wd, ld, tg, exp_retired});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [72:0] e;
      logic        ok;
      if (reset) begin
         last_ret = retired;
      end else begin
         if (retired == last_ret + 32'd1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_commit: retired=%h with nothing expected", retired);
            end else begin
               e  = exp_q.pop_front();
               ok = (reg_we == e[72]) && (!e[72] || (reg_waddr == e[71:67] && reg_wdata == e[66:35]))
                    && (pc_load == e[34]) && (!e[34] || pc_target == e[33:32]) && (retired == e[31:0]);
               if (!ok) begin
                  bad++;
                  $display("FAIL commit: got we=%0b waddr=%0d wdata=%h load=%0b target=%0d retired=%h expected we=%0b waddr=%0d wdata=%h load=%0b target=%0d retired=%h",
                           reg_we, reg_waddr, reg_wdata, pc_load, pc_target, retired,
                           e[72], e[71:67], e[66:35], e[34], e[33:32], e[31:0]);
               end
            end
         end else if (reg_we || pc_load) begin
            total++;
            bad++;
            $display("FAIL spurious_pulse: got we=%0b load=%0b retired=%h expected no pulse", reg_we, pc_load, retired);
         end
         last_ret = retired;
         if (uart_valid && uart_ready) hs_cnt++;
      end
   end

   // stimulus
   initial begin
      reset = 1'b1; idle(); uart_valid = 1'b0; uart_data = '0; dbg_preload = 1'b0; dbg_value = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_reg_we", 32'(reg_we), 0);
      chk("rst_pc_load", 32'(pc_load), 0);
      chk("rst_waddr", 32'(reg_waddr), 0);
      chk("rst_wdata", reg_wdata, 0);
      chk("rst_target", 32'(pc_target), 0);
      chk("rst_retired", retired, 0);
      chk("rst_uart_ready", 32'(uart_ready), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_state", 32'(dbg_state), 32'(ST_RUN));

      step(); issue(1, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h1234, 5'd5, 26'h0, 2'd0, 2'd0);
      expect_commit(1, 5'd5, 32'h1234, 0, 2'd0);
      step(); issue(1, 2'b01, 2'b00, 0, 32'hDEADBEEF, 32'h0, 32'h9, 5'd7, 26'h0, 2'd0, 2'd0);
      expect_commit(1, 5'd7, 32'hDEADBEEF, 0, 2'd0);
      step(); issue(1, 2'b10, 2'b00, 0, 32'h0, 32'h0, 32'h9, 5'd31, 26'h0, 2'd3, 2'd0);
      expect_commit(1, 5'd31, 32'h3, 0, 2'd0);
      step(); issue(1, 2'b11, 2'b00, 0, 32'h0, 32'h0, 32'h55AA, 5'd1, 26'h0, 2'd0, 2'd0);
      expect_commit(1, 5'd1, 32'h55AA, 0, 2'd0);
      step(); issue(1, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h77, 5'd0, 26'h0, 2'd0, 2'd0);
      expect_commit(0, 5'd0, 32'h0, 0, 2'd0);
      step(); issue(0, 2'b00, 2'b01, 0, 32'h0, 32'h0, 32'h0, 5'd3, 26'h3FFFFFE, 2'd0, 2'd0);
      expect_commit(0, 5'd0, 32'h0, 1, 2'd2);
      step(); issue(0, 2'b00, 2'b10, 0, 32'h0, 32'h101, 32'h0, 5'd3, 26'h0, 2'd0, 2'd0);
      expect_commit(0, 5'd0, 32'h0, 1, 2'd1);
      step(); issue(0, 2'b00, 2'b11, 0, 32'h0, 32'h0, 32'h1, 5'd0, 26'h0, 2'd0, 2'd2);
      expect_commit(0, 5'd0, 32'h0, 1, 2'd2);
      step(); issue(0, 2'b00, 2'b11, 0, 32'h0, 32'h0, 32'h0, 5'd0, 26'h0, 2'd0, 2'd2);
      expect_commit(0, 5'd0, 32'h0, 0, 2'd0);
      step(); idle(); RegWrite = 1'b1; rdist = 5'd6; Branch = 2'b01;
      step(); idle();

      // UART byte already waiting: commits without a stall
      step(); issue(1, 2'b00, 2'b00, 1, 32'h0, 32'h0, 32'h0, 5'd9, 26'h0, 2'd0, 2'd0);
      uart_valid = 1'b1; uart_data = 8'h3C;
      expect_commit(1, 5'd9, 32'h3C, 0, 2'd0);
      @(negedge clk);
      chk("imm_uart_ready", 32'(uart_ready), 1);
      chk("imm_stall", 32'(stall), 0);
      step(); idle(); uart_valid = 1'b0;

      // UART byte three cycles late
      hs0 = hs_cnt;
      issue(1, 2'b00, 2'b01, 1, 32'h0, 32'h0, 32'h0, 5'd4, 26'h1, 2'd0, 2'd0);
      uart_data = 8'h11;
      expect_commit(1, 5'd4, 32'hA5, 1, 2'd1);
      @(negedge clk); chk("wait_stall0", 32'(stall), 1); chk("wait_ready0", 32'(uart_ready), 1);
      step(); issue(1, 2'b00, 2'b10, 0, 32'hFFFF, 32'h3, 32'h99, 5'd20, 26'h0, 2'd0, 2'd0);
      @(negedge clk); chk("wait_stall1", 32'(stall), 1); chk("wait_state", 32'(dbg_state), 32'(ST_UART_WAIT));
      step();
      @(negedge clk); chk("wait_stall2", 32'(stall), 1);
      step(); uart_valid = 1'b1; uart_data = 8'hA5;
      @(negedge clk); chk("wait_hs_ready", 32'(uart_ready), 1); chk("wait_hs_stall", 32'(stall), 1);
      step(); idle(); uart_valid = 1'b0;
      @(negedge clk);
      chk("wait_done_stall", 32'(stall), 0);
      chk("wait_done_state", 32'(dbg_state), 32'(ST_RUN));
      chk("wait_handshakes", 32'(hs_cnt - hs0), 1);

      // reset while parked discards the instruction
      step(); issue(1, 2'b00, 2'b00, 1, 32'h0, 32'h0, 32'h0, 5'd12, 26'h0, 2'd0, 2'd0);
      step(); idle();
      chk("park_state", 32'(dbg_state), 32'(ST_UART_WAIT));
      hs0 = hs_cnt;
      #2 reset = 1'b1; uart_valid = 1'b1; uart_data = 8'h5A;
      #1;
      chk("rstw_ready", 32'(uart_ready), 0);
      chk("rstw_state", 32'(dbg_state), 32'(ST_RUN));
      chk("rstw_retired", retired, 0);
      exp_retired = '0;
      step(); reset = 1'b0; uart_valid = 1'b0;
      step(); step();
      chk("rstw_retired_after", retired, 0);
      chk("rstw_handshakes", 32'(hs_cnt - hs0), 0);

      // retired wraps
      step(); dbg_preload = 1'b1; dbg_value = 32'hFFFFFFFF;
      step(); dbg_preload = 1'b0;
      @(negedge clk); chk("preload", retired, 32'hFFFFFFFF);
      exp_retired = 32'hFFFFFFFF;
      step(); issue(1, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h7, 5'd2, 26'h0, 2'd0, 2'd0);
      expect_commit(1, 5'd2, 32'h7, 0, 2'd0);
      step(); idle();
      @(negedge clk); chk("wrap_retired", retired, 32'h0);

      repeat (3) step();
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
